// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: 16-bit frames (cmd, data) into a 3-register file plus a
// read-only frame counter. SPI pins are synchronized into clk and edge-detected.
module spi_reg_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  REG0_RST    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] reg0_q,
  output logic [7:0] reg1_q,
  output logic [7:0] reg2_q,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, mosi_s, csn_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  // cs_n chain resets high so a released reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~csn_s & csn_prev_q;
  assign cs_rise   = csn_s & ~csn_prev_q;
  assign miso_oe   = ena & ~csn_s;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shin_q;
  logic [7:0] shout_q, frame_cnt_q, shin_nxt, rdata;
  logic       wr_q;
  logic [1:0] addr_q;

  assign shin_nxt = {shin_q, mosi_s};

  always_comb begin
    rdata = frame_cnt_q;
    case (shin_nxt[1:0])
      2'd0:    rdata = reg0_q;
      2'd1:    rdata = reg1_q;
      2'd2:    rdata = reg2_q;
      default: rdata = frame_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      frame_cnt_q <= '0;
      reg0_q      <= REG0_RST;
      reg1_q      <= '0;
      reg2_q      <= '0;
      miso        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_rise || !ena) begin
        state_q <= IDLE;
        miso    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            miso      <= 1'b0;
          end
          CMD: if (sclk_rise) begin
            shin_q    <= shin_nxt[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_q <= DATA;
              wr_q    <= shin_nxt[7];
              addr_q  <= shin_nxt[1:0];
              // Snapshot read data now; write frames shift out zeros.
              shout_q <= shin_nxt[7] ? 8'h00 : rdata;
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shin_q    <= shin_nxt[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                state_q     <= DONE;
                miso        <= 1'b0;
                frame_done  <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 8'd1;
                if (wr_q) begin
                  case (addr_q)
                    2'd0:    reg0_q <= shin_nxt;
                    2'd1:    reg1_q <= shin_nxt;
                    2'd2:    reg2_q <= shin_nxt;
                    default: ;
                  endcase
                end
              end
            end else if (sclk_fall) begin
              miso    <= shout_q[7];
              shout_q <= {shout_q[6:0], 1'b0};
            end
          end
          default: miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized self-checking bench for spi_reg_responder against a frame-level model.
module tb_spi_reg_responder;
  localparam logic [7:0] REG0_RST = 8'h00;
  localparam int HALF = 5;

  logic clk = 0, rst_n = 0, ena = 1, sclk = 0, cs_n = 1, mosi = 0;
  logic miso, miso_oe, frame_done;
  logic [7:0] reg0_q, reg1_q, reg2_q;

  spi_reg_responder #(.SYNC_STAGES(2), .REG0_RST(REG0_RST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg0_q(reg0_q), .reg1_q(reg1_q),
    .reg2_q(reg2_q), .frame_done(frame_done));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, fd_cnt = 0;
  logic [7:0] m_reg [0:3];
  logic [7:0] m_cnt;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic model_reset();
    m_reg[0] = REG0_RST; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0; m_cnt = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock nbits bits from the top of 'bits'; miso seen at rise i lands in got[23-i].
  task automatic send_bits(input int nbits, input logic [23:0] bits, output logic [23:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[23-i];
      wait_clk(HALF);
      got[23-i] = miso;
      sclk = 1;
      wait_clk(HALF);
      sclk = 0;
    end
    wait_clk(HALF);
  endtask

  task automatic check_regs(input string name);
    checks++;
    if (reg0_q !== m_reg[0] || reg1_q !== m_reg[1] || reg2_q !== m_reg[2]) begin
      failures++;
      $display("FAIL %s regs: got %h %h %h expected %h %h %h", name,
               reg0_q, reg1_q, reg2_q, m_reg[0], m_reg[1], m_reg[2]);
    end
  endtask

  task automatic do_frame(input int nbits, input logic [23:0] bits, input string name);
    logic [23:0] got, exp, mask;
    logic [7:0] cmd, dat, rd;
    int fd0;
    bit full;
    cmd = bits[23:16]; dat = bits[15:8];
    full = (nbits >= 16);
    rd = (cmd[1:0] == 2'd3) ? m_cnt : m_reg[cmd[1:0]];
    exp = cmd[7] ? 24'h0 : {8'h00, rd, 8'h00};
    mask = ~(24'hFFFFFF >> nbits);
    exp = exp & mask;
    fd0 = fd_cnt;
    cs_n = 0;
    wait_clk(6);
    checks++;
    if (miso_oe !== 1'b1) begin
      failures++; $display("FAIL %s miso_oe_active: got %b expected 1", name, miso_oe);
    end
    send_bits(nbits, bits, got);
    cs_n = 1;
    wait_clk(8);
    if (full) begin
      if (cmd[7] && cmd[1:0] != 2'd3) m_reg[cmd[1:0]] = dat;
      m_cnt = m_cnt + 8'd1;
      m_reg[3] = m_cnt;
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL %s miso: got %h expected %h", name, got, exp);
    end
    checks++;
    if (fd_cnt - fd0 != (full ? 1 : 0)) begin
      failures++; $display("FAIL %s frame_done: got %0d pulses expected %0d", name, fd_cnt - fd0, full ? 1 : 0);
    end
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++; $display("FAIL %s miso_oe_idle: got %b expected 0", name, miso_oe);
    end
    check_regs(name);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    wait_clk(3);
    checks++;
    if (miso_oe !== 1'b0 || miso !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL reset outputs: got oe=%b miso=%b fd=%b expected 0 0 0", miso_oe, miso, frame_done);
    end
    check_regs("reset");
    rst_n = 1;
    wait_clk(4);
    do_frame(16, {8'h03, 8'h00, 8'h00}, "reset_read_cnt");
  endtask

  task automatic test_write_read();
    do_frame(16, {8'h81, 8'hA5, 8'h00}, "write_reg1");
    checks++;
    if (reg1_q !== 8'hA5) begin
      failures++; $display("FAIL write_reg1_const: got %h expected a5", reg1_q);
    end
    do_frame(16, {8'h01, 8'h00, 8'h00}, "read_reg1");
    do_frame(16, {8'h82, 8'h3C, 8'h00}, "write_reg2");
    do_frame(16, {8'h7E, 8'h00, 8'h00}, "read_reg2_ignored_bits");
  endtask

  task automatic test_ro_wrap();
    logic [7:0] c;
    do_frame(16, {8'h83, 8'hFF, 8'h00}, "write_ro");
    for (int i = 0; i < 256; i++) begin
      c = $urandom;
      do_frame(16, {c, 8'($urandom), 8'h00}, "wrap_frame");
    end
    do_frame(16, {8'h03, 8'h00, 8'h00}, "wrap_read_cnt");
  endtask

  task automatic test_abort();
    do_frame(12, {8'h82, 8'h3C ^ 8'hFF, 8'h00}, "abort_12");
    do_frame(10, {8'h00, 8'h00, 8'h00}, "abort_read_10");
    do_frame(16, {8'h03, 8'h00, 8'h00}, "abort_cnt_read");
  endtask

  task automatic test_overlong();
    do_frame(24, {8'h80, 8'h5A, 8'hFF}, "overlong_write");
    checks++;
    if (reg0_q !== 8'h5A) begin
      failures++; $display("FAIL overlong_reg0: got %h expected 5a", reg0_q);
    end
    do_frame(24, {8'h00, 8'hFF, 8'hFF}, "overlong_read");
  endtask

  task automatic test_ena_mid_frame();
    logic [23:0] got;
    int fd0;
    fd0 = fd_cnt;
    cs_n = 0;
    wait_clk(6);
    send_bits(4, {8'h81, 8'h11, 8'h00}, got);
    ena = 0;
    wait_clk(6);
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++; $display("FAIL ena_off_oe: got %b expected 0", miso_oe);
    end
    ena = 1;
    send_bits(16, {8'h82, 8'h77, 8'h00}, got);
    cs_n = 1;
    wait_clk(8);
    checks++;
    if (fd_cnt != fd0) begin
      failures++; $display("FAIL ena_abort_fd: got %0d pulses expected 0", fd_cnt - fd0);
    end
    check_regs("ena_abort");
    do_frame(16, {8'h80, 8'hC3, 8'h00}, "ena_next_write");
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] got;
    cs_n = 0;
    wait_clk(6);
    send_bits(6, {8'h81, 8'h00, 8'h00}, got);
    rst_n = 0;
    model_reset();
    wait_clk(2);
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++; $display("FAIL rst_mid_oe: got %b expected 0", miso_oe);
    end
    check_regs("rst_mid");
    cs_n = 1;
    wait_clk(4);
    rst_n = 1;
    wait_clk(4);
    do_frame(16, {8'h82, 8'h9D, 8'h00}, "rst_next_write");
    do_frame(16, {8'h03, 8'h00, 8'h00}, "rst_cnt_read");
  endtask

  task automatic test_random();
    int r, n;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      n = (r <= 5) ? 16 : (r == 6) ? 20 : (r == 7) ? 24 : $urandom_range(1, 15);
      do_frame(n, 24'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_overlong();
    test_ena_mid_frame();
    test_reset_mid_frame();
    test_random();
    test_ro_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
